// File: rtl/booth8_pkg.sv
// Shared constants and state encoding for the radix-8 Booth mantissa multiplier.
// Used by both the selector/encoder side and the partial-product accumulator.
package booth8_pkg;

    localparam int PP_W       = 26;
    localparam int NUM_DIGITS = 9;
    localparam int PROD_W     = 48;
    localparam int ACC_W      = PP_W + 3;
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1);

    // Bits of acc_hi that land in the product above the 27 acc_lo bits
    localparam int HI_W = PROD_W - (PP_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/booth8_pp_term.sv
// Turns a one's-complement selector output into an exact signed term.
// The +1 completes the two's-complement negate the selector left undone.
module booth8_pp_term
    import booth8_pkg::*;
(
    input  logic [PP_W-1:0] pp,
    input  logic            pp_neg,
    output logic [ACC_W:0]  term
);

    logic [PP_W:0] raw;

    assign raw  = {pp_neg, pp};
    assign term = {{(ACC_W - PP_W){raw[PP_W]}}, raw}
                + {{ACC_W{1'b0}}, pp_neg};

endmodule

// File: rtl/booth8_pp_accumulator.sv
// Sequential accumulator of radix-8 Booth partial products, LS digit first,
// presenting the 48-bit unsigned mantissa product over a valid/ready handshake.
module booth8_pp_accumulator
    import booth8_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pp_valid,
    output logic              pp_ready,
    input  logic [PP_W-1:0]   pp,
    input  logic              pp_neg,
    input  logic              pp_first,
    output logic              prod_valid,
    input  logic              prod_ready,
    output logic [PROD_W-1:0] prod,
    output logic              err_seq
);

    state_t state, state_nx;

    logic [ACC_W-1:0]  acc_hi, acc_hi_nx;
    logic [PP_W:0]     acc_lo, acc_lo_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [PROD_W-1:0] prod_nx;
    logic              prod_valid_nx;
    logic              err_nx;

    logic [ACC_W:0]    term;
    logic [ACC_W:0]    base;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  sum_hi;
    logic [PP_W:0]     sum_lo;

    booth8_pp_term u_term (
        .pp     (pp),
        .pp_neg (pp_neg),
        .term   (term)
    );

    // A first digit starts from zero, so no clearing cycle is needed
    assign base   = pp_first ? '0 : {acc_hi[ACC_W-1], acc_hi};
    assign sum    = base + term;
    assign sum_hi = {{2{sum[ACC_W]}}, sum[ACC_W:3]};
    assign sum_lo = {sum[2:0], acc_lo[PP_W:3]};

    assign pp_ready = (state != DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc_hi     <= '0;
            acc_lo     <= '0;
            cnt        <= '0;
            prod       <= '0;
            prod_valid <= 1'b0;
            err_seq    <= 1'b0;
        end else begin
            state      <= state_nx;
            acc_hi     <= acc_hi_nx;
            acc_lo     <= acc_lo_nx;
            cnt        <= cnt_nx;
            prod       <= prod_nx;
            prod_valid <= prod_valid_nx;
            err_seq    <= err_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        acc_hi_nx     = acc_hi;
        acc_lo_nx     = acc_lo;
        cnt_nx        = cnt;
        prod_nx       = prod;
        prod_valid_nx = prod_valid;
        err_nx        = err_seq;
        unique case (state)
            IDLE: begin
                if (pp_valid) begin
                    if (pp_first) begin
                        acc_hi_nx = sum_hi;
                        acc_lo_nx = sum_lo;
                        cnt_nx    = CNT_W'(1);
                        state_nx  = ACCUM;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (pp_valid) begin
                    acc_hi_nx = sum_hi;
                    acc_lo_nx = sum_lo;
                    if (pp_first) begin
                        err_nx = 1'b1;
                        cnt_nx = CNT_W'(1);
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(NUM_DIGITS - 1)) begin
                            prod_nx       = {sum_hi[HI_W-1:0], sum_lo};
                            prod_valid_nx = 1'b1;
                            state_nx      = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (prod_ready) begin
                    prod_valid_nx = 1'b0;
                    state_nx      = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_booth8_pp_accumulator.sv
// Self-checking bench: Booth digits and products come from plain integer arithmetic.
// Table vectors, random operands and hand-written stall/restart/reset sequences.
module tb_booth8_pp_accumulator;
    import booth8_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pp_valid = 1'b0;
    logic              pp_ready;
    logic [PP_W-1:0]   pp = '0;
    logic              pp_neg = 1'b0;
    logic              pp_first = 1'b0;
    logic              prod_valid;
    logic              prod_ready = 1'b0;
    logic [PROD_W-1:0] prod;
    logic              err_seq;

    logic [PP_W-1:0]   t_pp = '0;
    logic              t_neg = 1'b0;
    logic [ACC_W:0]    t_term;

    int compared = 0;
    int mismatched = 0;

    logic [PP_W-1:0] dig_pp [NUM_DIGITS];
    logic            dig_neg[NUM_DIGITS];

    typedef struct {
        logic [22:0] a;
        logic [22:0] b;
        int          gap;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    booth8_pp_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pp_valid   (pp_valid),
        .pp_ready   (pp_ready),
        .pp         (pp),
        .pp_neg     (pp_neg),
        .pp_first   (pp_first),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod       (prod),
        .err_seq    (err_seq)
    );

    booth8_pp_term u_term_chk (
        .pp     (t_pp),
        .pp_neg (t_neg),
        .term   (t_term)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_prod(input logic [22:0] a,
                                               input logic [22:0] b);
        longint unsigned x;
        longint unsigned y;
        x = longint'({1'b1, a});
        y = longint'({1'b1, b});
        return x * y;
    endfunction

    // Radix-8 recoding of {1,b} zero-extended to 27 bits, multiplicand {1,a}
    task automatic make_digits(input logic [22:0] a, input logic [22:0] b);
        logic [27:0]     ext;
        logic [PP_W-1:0] m;
        longint          y;
        longint          mag;
        int              d;
        y   = longint'({1'b1, a});
        ext = {3'b000, 1'b1, b, 1'b0};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = -4 * int'(ext[3*i+3]) + 2 * int'(ext[3*i+2])
              + int'(ext[3*i+1]) + int'(ext[3*i]);
            mag = longint'(d < 0 ? -d : d) * y;
            m = mag[PP_W-1:0];
            dig_neg[i] = (d < 0);
            dig_pp[i]  = (d < 0) ? ~m : m;
        end
    endtask

    task automatic send_beat(input logic [PP_W-1:0] p, input logic n,
                             input logic f, input int gap);
        int waited;
        waited = 0;
        pp_valid = 1'b0;
        repeat (gap) tick();
        while (!pp_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("pp_ready_before_beat", 64'(pp_ready), 64'd1);
        pp       = p;
        pp_neg   = n;
        pp_first = f;
        pp_valid = 1'b1;
        tick();
        pp_valid = 1'b0;
        pp_first = 1'b0;
    endtask

    task automatic stream(input int lo, input int hi, input int max_gap);
        for (int i = lo; i <= hi; i++) begin
            send_beat(dig_pp[i], dig_neg[i], (i == 0),
                      int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic handshake();
        prod_ready = 1'b1;
        tick();
        prod_ready = 1'b0;
        check("prod_valid_after_hs", 64'(prod_valid), 64'd0);
        check("pp_ready_after_hs", 64'(pp_ready), 64'd1);
    endtask

    task automatic run_product(input logic [22:0] a, input logic [22:0] b,
                               input int max_gap, input logic [47:0] exp,
                               input string name);
        make_digits(a, b);
        stream(0, NUM_DIGITS - 1, max_gap);
        check({name, "_valid"}, 64'(prod_valid), 64'd1);
        check(name, 64'(prod), 64'(exp));
        handshake();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [22:0]  ra;
        logic [22:0]  rb;
        logic [47:0]  held;
        longint       y;
        longint       mag;
        longint       got;
        logic [PP_W-1:0] m;

        vecs[0] = '{23'h000000, 23'h000000, 0, 48'h400000000000};
        vecs[1] = '{23'h7FFFFF, 23'h7FFFFF, 0, 48'hFFFFFE000001};
        vecs[2] = '{23'h400000, 23'h400000, 3, 48'h900000000000};
        vecs[3] = '{23'h400000, 23'h400000, 0, 48'h900000000000};
        vecs[4] = '{23'h000000, 23'h7FFFFF, 1, 48'h7FFFFF800000};

        // Standalone term former: exactly k*Y for k in -4..4
        for (int k = -4; k <= 4; k++) begin
            y   = longint'({1'b1, 23'($urandom)});
            mag = longint'(k < 0 ? -k : k) * y;
            m   = mag[PP_W-1:0];
            t_neg = (k < 0);
            t_pp  = (k < 0) ? ~m : m;
            #1;
            got = longint'($signed(t_term));
            check("term", 64'(got), 64'(longint'(k) * y));
        end
        t_neg = 1'b1;
        t_pp  = '1;
        #1;
        got = longint'($signed(t_term));
        check("term_neg_zero", 64'(got), 64'd0);

        repeat (2) tick();
        check("rst_prod_valid", 64'(prod_valid), 64'd0);
        check("rst_pp_ready", 64'(pp_ready), 64'd1);
        check("rst_prod", 64'(prod), 64'd0);
        check("rst_err_seq", 64'(err_seq), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            run_product(vecs[v].a, vecs[v].b, vecs[v].gap, vecs[v].exp, "vec_prod");
        end
        check("err_seq_clean", 64'(err_seq), 64'd0);

        for (int r = 0; r < 20; r++) begin
            ra = 23'($urandom);
            rb = 23'($urandom);
            run_product(ra, rb, 2, model_prod(ra, rb), "rand_prod");
        end

        // Downstream stall: block must refuse beats and hold the product
        ra = 23'h1A2B3C;
        rb = 23'h0F0F0F;
        make_digits(ra, rb);
        stream(0, NUM_DIGITS - 1, 0);
        held = model_prod(ra, rb);
        for (int c = 0; c < 20; c++) begin
            tick();
            check("stall_pp_ready", 64'(pp_ready), 64'd0);
            check("stall_prod", 64'(prod), 64'(held));
            check("stall_valid", 64'(prod_valid), 64'd1);
        end
        handshake();
        run_product(23'h7FFFFF, 23'h000000, 0, 48'h7FFFFF800000, "post_stall");

        // Restart mid-product with a stray first digit
        make_digits(23'h3FFFFF, 23'h2AAAAA);
        stream(0, 4, 0);
        check("err_before_restart", 64'(err_seq), 64'd0);
        ra = 23'h555555;
        rb = 23'h123456;
        run_product(ra, rb, 1, model_prod(ra, rb), "restart_prod");
        check("err_after_restart", 64'(err_seq), 64'd1);

        // Orphan beat in IDLE is dropped; err stays sticky
        send_beat('0, 1'b0, 1'b0, 0);
        check("idle_orphan_valid", 64'(prod_valid), 64'd0);
        run_product(23'h000000, 23'h000000, 0, 48'h400000000000, "after_orphan");
        check("err_sticky", 64'(err_seq), 64'd1);

        // Asynchronous reset after digit 4
        make_digits(23'h654321, 23'h7ABCDE);
        stream(0, 4, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_prod_valid", 64'(prod_valid), 64'd0);
        check("midrst_pp_ready", 64'(pp_ready), 64'd1);
        check("midrst_err_seq", 64'(err_seq), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_product(23'h000000, 23'h000000, 0, 48'h400000000000, "after_rst");

        // Asynchronous reset while a product is waiting
        make_digits(23'h7FFFFF, 23'h7FFFFF);
        stream(0, NUM_DIGITS - 1, 0);
        check("done_valid", 64'(prod_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("donerst_prod_valid", 64'(prod_valid), 64'd0);
        check("donerst_prod", 64'(prod), 64'd0);
        check("donerst_pp_ready", 64'(pp_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_product(23'h7FFFFF, 23'h7FFFFF, 0, 48'hFFFFFE000001, "after_donerst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
